// File: rtl/hd_sync_gen_pkg.sv
// 720p50 timing constants, genlock state encoding and a window decode helper
// shared by the HD sync generator files.
package hd_sync_gen_pkg;

   localparam int unsigned H_W = 12;
   localparam int unsigned V_W = 11;

   localparam int unsigned HD_PIX_DIV  = 2;
   localparam int unsigned HD_H_ACTIVE = 1280;
   localparam int unsigned HD_H_FP     = 440;
   localparam int unsigned HD_H_SYNC   = 40;
   localparam int unsigned HD_H_BP     = 220;
   localparam int unsigned HD_V_ACTIVE = 720;
   localparam int unsigned HD_V_FP     = 5;
   localparam int unsigned HD_V_SYNC   = 5;
   localparam int unsigned HD_V_BP     = 20;
   localparam int unsigned HD_V_LOCK   = 725;
   localparam int unsigned HD_LOCK_TOL = 2;

   typedef enum logic [1:0] {
      ST_FREE   = 2'd0,
      ST_SEEK   = 2'd1,
      ST_LOCKED = 2'd2
   } lock_state_e;

   // True when x lies in [lo, lo+len)
   function automatic logic in_win(input logic [H_W-1:0] x,
                                   input int unsigned     lo,
                                   input int unsigned     len);
      return (x >= H_W'(lo)) && (x < H_W'(lo + len));
   endfunction

endpackage

// File: rtl/hd_pix_div.sv
// Pixel clock divider.
//  clk, rst : system clock, async active-high reset
//  pix_en   : one-clk pulse in the cycle after div_cnt == PIX_DIV-1
//  hd_clk   : high while div_cnt < PIX_DIV/2 (low in reset)
module hd_pix_div
   import hd_sync_gen_pkg::*;
#(
   parameter int unsigned PIX_DIV = HD_PIX_DIV
) (
   input  logic clk,
   input  logic rst,
   output logic pix_en,
   output logic hd_clk
);

   localparam int unsigned DIV_W = (PIX_DIV > 2) ? $clog2(PIX_DIV) : 1;

   logic [DIV_W-1:0] div_cnt;
   logic [DIV_W-1:0] div_nxt;
   logic             div_last;

   // Wrapping divide counter
   always_comb begin
      div_last = (div_cnt == DIV_W'(PIX_DIV - 1));
      div_nxt  = div_last ? '0 : div_cnt + DIV_W'(1);
   end

   // hd_clk is registered from the next count so it tracks div_cnt exactly
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         div_cnt <= '0;
         pix_en  <= 1'b0;
         hd_clk  <= 1'b0;
      end else begin
         div_cnt <= div_nxt;
         pix_en  <= div_last;
         hd_clk  <= (div_nxt < DIV_W'(PIX_DIV / 2));
      end
   end

endmodule

// File: rtl/hd_sync_gen.sv
// HD video timing generator with optional genlock to the PAL frame_end pulse.
//  clk, rst      : system clock, async active-high reset
//  i_genlock_en  : 1 = genlock to i_frame_end, 0 = free-run
//  i_frame_end   : one-clk pulse at the PAL vsync falling edge
//  o_pix_en      : one-clk pulse per HD pixel
//  o_hd_clk      : pixel clock
//  o_hd_hsync/o_hd_vsync/o_hd_de : sync and active-video decode
//  o_h_pos/o_v_pos : current pixel / line
//  o_locked      : genlock achieved
module hd_sync_gen
   import hd_sync_gen_pkg::*;
#(
   parameter int unsigned PIX_DIV     = HD_PIX_DIV,
   parameter int unsigned H_ACTIVE    = HD_H_ACTIVE,
   parameter int unsigned H_FP        = HD_H_FP,
   parameter int unsigned H_SYNC      = HD_H_SYNC,
   parameter int unsigned H_BP        = HD_H_BP,
   parameter int unsigned V_ACTIVE    = HD_V_ACTIVE,
   parameter int unsigned V_FP        = HD_V_FP,
   parameter int unsigned V_SYNC      = HD_V_SYNC,
   parameter int unsigned V_BP        = HD_V_BP,
   parameter logic        HS_POL      = 1'b1,
   parameter logic        VS_POL      = 1'b1,
   parameter int unsigned V_LOCK_LINE = HD_V_LOCK,
   parameter int unsigned LOCK_TOL    = HD_LOCK_TOL
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           i_genlock_en,
   input  logic           i_frame_end,
   output logic           o_pix_en,
   output logic           o_hd_clk,
   output logic           o_hd_hsync,
   output logic           o_hd_vsync,
   output logic           o_hd_de,
   output logic [H_W-1:0] o_h_pos,
   output logic [V_W-1:0] o_v_pos,
   output logic           o_locked
);

   localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

   lock_state_e    state;
   lock_state_e    state_nxt;
   logic [1:0]     miss_cnt;
   logic [1:0]     miss_nxt;
   logic           fe_pend;
   logic           fe_now;
   logic           jump;
   logic           eol;
   logic           v_wrap;
   logic [V_W-1:0] err;
   logic [H_W-1:0] h_cnt;
   logic [V_W-1:0] v_cnt;
   logic [H_W-1:0] h_nxt;
   logic [V_W-1:0] v_nxt;

   hd_pix_div #(
      .PIX_DIV (PIX_DIV)
   ) u_pix_div (
      .clk    (clk),
      .rst    (rst),
      .pix_en (o_pix_en),
      .hd_clk (o_hd_clk)
   );

   // A frame_end on a pix_en edge is consumed on that edge, so merge it with the pending flag
   always_comb begin
      fe_now = fe_pend | i_frame_end;
      eol    = (h_cnt == H_W'(H_TOTAL - 1));
      v_wrap = o_pix_en && eol && (v_cnt == V_W'(V_TOTAL - 1));
      err    = (v_cnt >= V_W'(V_LOCK_LINE)) ? v_cnt - V_W'(V_LOCK_LINE)
                                            : V_W'(V_LOCK_LINE) - v_cnt;
   end

   // Genlock next-state, miss counter and jump request
   always_comb begin
      state_nxt = state;
      miss_nxt  = miss_cnt;
      jump      = 1'b0;
      case (state)
         ST_FREE: begin
            miss_nxt = 2'd0;
            state_nxt = ST_SEEK;
         end
         ST_SEEK: begin
            miss_nxt = 2'd0;
            if (o_pix_en && fe_now) begin
               jump      = 1'b1;
               state_nxt = ST_LOCKED;
            end
         end
         ST_LOCKED: begin
            if (o_pix_en && fe_now) begin
               miss_nxt = 2'd0;
               if (err > V_W'(LOCK_TOL)) state_nxt = ST_SEEK;
            end else if (v_wrap && (miss_cnt != 2'd3)) begin
               miss_nxt = miss_cnt + 2'd1;
            end
            if (miss_nxt == 2'd2) state_nxt = ST_SEEK;
         end
         default: state_nxt = ST_FREE;
      endcase
      // Disabling genlock wins in every state and never moves the counters
      if (!i_genlock_en) begin
         state_nxt = ST_FREE;
         miss_nxt  = 2'd0;
         jump      = 1'b0;
      end
   end

   // Genlock state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= ST_FREE;
         miss_cnt <= 2'd0;
         o_locked <= 1'b0;
      end else begin
         state    <= state_nxt;
         miss_cnt <= miss_nxt;
         o_locked <= (state_nxt == ST_LOCKED);
      end
   end

   // Next raster position: forced on a lock jump, otherwise advance per pixel
   always_comb begin
      h_nxt = h_cnt;
      v_nxt = v_cnt;
      if (jump) begin
         h_nxt = '0;
         v_nxt = V_W'(V_LOCK_LINE);
      end else if (o_pix_en) begin
         if (eol) begin
            h_nxt = '0;
            v_nxt = (v_cnt == V_W'(V_TOTAL - 1)) ? '0 : v_cnt + V_W'(1);
         end else begin
            h_nxt = h_cnt + H_W'(1);
         end
      end
   end

   // Counters plus decode from the next position so all outputs change together
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         h_cnt      <= '0;
         v_cnt      <= '0;
         fe_pend    <= 1'b0;
         o_hd_de    <= 1'b0;
         o_hd_hsync <= ~HS_POL;
         o_hd_vsync <= ~VS_POL;
      end else begin
         h_cnt   <= h_nxt;
         v_cnt   <= v_nxt;
         fe_pend <= o_pix_en ? 1'b0 : fe_now;
         if (o_pix_en) begin
            o_hd_de    <= (h_nxt < H_W'(H_ACTIVE)) && (v_nxt < V_W'(V_ACTIVE));
            o_hd_hsync <= in_win(h_nxt, H_ACTIVE + H_FP, H_SYNC) ? HS_POL : ~HS_POL;
            o_hd_vsync <= in_win(H_W'(v_nxt), V_ACTIVE + V_FP, V_SYNC) ? VS_POL : ~VS_POL;
         end
      end
   end

   assign o_h_pos = h_cnt;
   assign o_v_pos = v_cnt;

endmodule

// File: tb/tb_hd_sync_gen.sv
// Directed bench for hd_sync_gen on a shrunken raster (16 x 12, lock line 8)
// so full frames fit in a short run.
module tb_hd_sync_gen;

   localparam int unsigned HT = 16;
   localparam int unsigned VT = 12;

   logic        clk = 1'b0;
   logic        rst;
   logic        genlock_en;
   logic        frame_end;
   logic        pix_en;
   logic        hd_clk;
   logic        hs;
   logic        vs;
   logic        de;
   logic [11:0] h_pos;
   logic [10:0] v_pos;
   logic        locked;

   int checks = 0;
   int errors = 0;

   hd_sync_gen #(
      .PIX_DIV     (2),
      .H_ACTIVE    (8),
      .H_FP        (3),
      .H_SYNC      (2),
      .H_BP        (3),
      .V_ACTIVE    (6),
      .V_FP        (2),
      .V_SYNC      (2),
      .V_BP        (2),
      .HS_POL      (1'b1),
      .VS_POL      (1'b1),
      .V_LOCK_LINE (8),
      .LOCK_TOL    (2)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .i_genlock_en (genlock_en),
      .i_frame_end  (frame_end),
      .o_pix_en     (pix_en),
      .o_hd_clk     (hd_clk),
      .o_hd_hsync   (hs),
      .o_hd_vsync   (vs),
      .o_hd_de      (de),
      .o_h_pos      (h_pos),
      .o_v_pos      (v_pos),
      .o_locked     (locked)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Advance until the raster reaches (h, v) on a non-pix_en cycle
   task automatic wait_pos(input int h, input int v);
      int n;
      n = 0;
      do begin
         step();
         n++;
      end while (!((int'(h_pos) == h) && (int'(v_pos) == v) && !pix_en) && (n < 2000));
      chk("wait_pos", {pix_en, 12'(h_pos), 11'(v_pos)}, {1'b0, 12'(h), 11'(v)});
   endtask

   // One-clk frame_end pulse; its edge is a non-pix_en edge when called after wait_pos
   task automatic pulse_fe();
      frame_end = 1'b1;
      step();
      frame_end = 1'b0;
   endtask

   task automatic chk_pos(input string tag, input int h, input int v, input logic lk);
      chk({tag, "_h"}, 32'(h_pos), 32'(h));
      chk({tag, "_v"}, 32'(v_pos), 32'(v));
      chk({tag, "_locked"}, 32'(locked), 32'(lk));
   endtask

   initial begin
      int p;
      int eh;
      int ev;
      rst        = 1'b1;
      genlock_en = 1'b0;
      frame_end  = 1'b0;
      repeat (3) step();

      // Reset state
      chk("rst_pix_en", 32'(pix_en), 0);
      chk("rst_hd_clk", 32'(hd_clk), 0);
      chk("rst_de", 32'(de), 0);
      chk("rst_hs", 32'(hs), 0);
      chk("rst_vs", 32'(vs), 0);
      chk_pos("rst", 0, 0, 1'b0);

      // Free-run across a frame wrap: model position from clocks since reset release
      rst = 1'b0;
      for (int c = 1; c <= 420; c++) begin
         step();
         p  = (c - 1) / 2;
         eh = p % HT;
         ev = (p / HT) % VT;
         chk("fr_h", 32'(h_pos), 32'(eh));
         chk("fr_v", 32'(v_pos), 32'(ev));
         chk("fr_pix_en", 32'(pix_en), 32'((c >= 2) && (c % 2 == 0)));
         chk("fr_hd_clk", 32'(hd_clk), 32'(c % 2 == 0));
         if (c >= 3) begin
            chk("fr_de", 32'(de), 32'((eh < 8) && (ev < 6)));
            chk("fr_hs", 32'(hs), 32'((eh >= 11) && (eh < 13)));
            chk("fr_vs", 32'(vs), 32'((ev >= 8) && (ev < 10)));
         end else begin
            chk("fr_de0", 32'(de), 0);
            chk("fr_hs0", 32'(hs), 0);
            chk("fr_vs0", 32'(vs), 0);
         end
         chk("fr_locked", 32'(locked), 0);
      end

      // Genlock acquire: frame_end at v=2 jumps to (0,8) on the next pix_en edge
      genlock_en = 1'b1;
      wait_pos(0, 2);
      pulse_fe();
      chk_pos("seek_pend", 0, 2, 1'b0);
      step();
      chk_pos("acq", 0, 8, 1'b1);
      chk("acq_vs", 32'(vs), 1);
      chk("acq_de", 32'(de), 0);

      // Periodic frame_end one frame apart: no jump, h keeps counting
      wait_pos(0, 8);
      pulse_fe();
      step();
      chk_pos("per1", 1, 8, 1'b1);
      wait_pos(0, 8);
      pulse_fe();
      step();
      chk_pos("per2", 1, 8, 1'b1);

      // Phase error 2 keeps lock, error 3 drops to seek without jumping
      wait_pos(3, 10);
      pulse_fe();
      step();
      chk_pos("err2", 4, 10, 1'b1);
      wait_pos(3, 11);
      pulse_fe();
      step();
      chk_pos("err3", 4, 11, 1'b0);
      wait_pos(5, 1);
      pulse_fe();
      step();
      chk_pos("relock", 0, 8, 1'b1);

      // frame_end stops: lock survives one wrap, drops on the second
      wait_pos(0, 0);
      chk("miss1_locked", 32'(locked), 1);
      wait_pos(0, 0);
      chk_pos("miss2", 0, 0, 1'b0);
      step();
      step();
      chk_pos("miss2_cont", 1, 0, 1'b0);

      // frame_end coincident with pix_en is consumed on that same edge
      wait_pos(2, 3);
      step();
      chk("coin_pix_en", 32'(pix_en), 1);
      frame_end = 1'b1;
      step();
      frame_end = 1'b0;
      chk_pos("coin", 0, 8, 1'b1);

      // Genlock disabled while locked: free-run with no discontinuity, frame_end ignored
      wait_pos(4, 9);
      genlock_en = 1'b0;
      step();
      chk_pos("dis", 4, 9, 1'b0);
      step();
      chk_pos("dis_cont", 5, 9, 1'b0);
      pulse_fe();
      step();
      chk_pos("free_fe", 6, 9, 1'b0);

      // Async reset mid-line takes effect without a clock edge
      wait_pos(3, 2);
      chk("pre_rst_de", 32'(de), 1);
      #2;
      rst = 1'b1;
      #1;
      chk_pos("arst", 0, 0, 1'b0);
      chk("arst_de", 32'(de), 0);
      chk("arst_hs", 32'(hs), 0);
      chk("arst_vs", 32'(vs), 0);
      chk("arst_pix_en", 32'(pix_en), 0);
      chk("arst_hd_clk", 32'(hd_clk), 0);
      step();
      rst = 1'b0;
      repeat (4) step();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
